huffman_stream_decoder: RTL and testbench

Parametrised successor to the fixed-table Huffman decoder FSM. It integrates the bit buffer, a run-time programmable code table, and valid/ready handshakes on both the input and output streams. It decodes up to one symbol per clock with full backpressure. It sits between the packed-bit input stream and the signed-sample consumer in the decode datapath.

---
 rtl/huffman_stream_decoder.sv | 141 ++++++++++++++
 tb/tb_huffman_stream_decoder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/huffman_stream_decoder.sv
// Streaming Huffman decoder: bit buffer, run-time programmable code table,
// valid/ready on input beats and output symbols, one symbol per clock.
module huffman_stream_decoder #(
  parameter int MAX_CODE  = 9,
  parameter int SYM_W     = 4,
  parameter int NUM_CODES = 16,
  parameter int IN_W      = 4,
  parameter int BUF_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             stop,
  input  logic                             cfg_we,
  input  logic [$clog2(NUM_CODES)-1:0]     cfg_idx,
  input  logic [MAX_CODE-1:0]              cfg_code,
  input  logic [$clog2(MAX_CODE+1)-1:0]    cfg_len,
  input  logic [SYM_W-1:0]                 cfg_sym,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_data,
  input  logic [$clog2(IN_W+1)-1:0]        in_len,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SYM_W-1:0]                 out_data,
  output logic                             err,
  output logic [$clog2(BUF_W+1)-1:0]       bit_count
);

  localparam int LEN_W = $clog2(MAX_CODE+1);
  localparam int INL_W = $clog2(IN_W+1);
  localparam int CNT_W = $clog2(BUF_W+1);

  typedef enum logic [1:0] {S_CFG, S_RUN, S_ERR} state_t;

  state_t                 state;
  logic [BUF_W-1:0]       bit_buf;
  logic [MAX_CODE-1:0]    tbl_code [NUM_CODES];
  logic [LEN_W-1:0]       tbl_len  [NUM_CODES];
  logic [SYM_W-1:0]       tbl_sym  [NUM_CODES];

  logic                   hit;
  logic                   ok;
  logic [LEN_W-1:0]       hit_len;
  logic [SYM_W-1:0]       hit_sym;
  logic [INL_W-1:0]       in_len_c;
  logic [BUF_W-1:0]       in_bits;
  logic                   fire;
  logic                   accept;
  logic [LEN_W-1:0]       shift_len;
  logic [CNT_W-1:0]       base_count;
  logic [BUF_W-1:0]       next_buf;
  logic [CNT_W-1:0]       next_count;

  // Lowest matching index wins; entries with len 0 never match.
  always_comb begin
    hit     = 1'b0;
    ok      = 1'b0;
    hit_len = '0;
    hit_sym = '0;
    for (int unsigned i = 0; i < NUM_CODES; i++) begin
      ok = (tbl_len[i] != '0) && (32'(tbl_len[i]) <= 32'(bit_count));
      for (int unsigned b = 0; b < MAX_CODE; b++) begin
        if ((b < 32'(tbl_len[i])) && (bit_buf[b] != tbl_code[i][b]))
          ok = 1'b0;
      end
      if (ok && !hit) begin
        hit     = 1'b1;
        hit_len = tbl_len[i];
        hit_sym = tbl_sym[i];
      end
    end
  end

  always_comb begin
    in_len_c = (32'(in_len) > 32'(IN_W)) ? INL_W'(IN_W) : in_len;
    in_bits  = '0;
    for (int unsigned b = 0; b < IN_W; b++)
      in_bits[b] = in_data[b] & (b < 32'(in_len_c));
  end

  assign in_ready = (state == S_RUN) && (32'(bit_count) <= 32'(BUF_W - IN_W));
  assign accept   = in_valid && in_ready;
  assign fire     = (state == S_RUN) && hit && (!out_valid || out_ready);

  // Consume first, then append the new beat right above the surviving bits.
  always_comb begin
    shift_len  = fire ? hit_len : '0;
    base_count = bit_count - CNT_W'(shift_len);
    next_buf   = (bit_buf >> shift_len) | (accept ? (in_bits << base_count) : '0);
    next_count = base_count + (accept ? CNT_W'(in_len_c) : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_CFG;
      bit_buf   <= '0;
      bit_count <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_CODES; i++) begin
        tbl_code[i] <= '0;
        tbl_len[i]  <= '0;
        tbl_sym[i]  <= '0;
      end
    end else if (stop) begin
      state     <= S_CFG;
      bit_buf   <= '0;
      bit_count <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if ((state == S_CFG) && cfg_we) begin
        tbl_code[cfg_idx] <= cfg_code;
        tbl_len[cfg_idx]  <= cfg_len;
        tbl_sym[cfg_idx]  <= cfg_sym;
      end
      bit_buf   <= next_buf;
      bit_count <= next_count;
      if (fire) begin
        out_valid <= 1'b1;
        out_data  <= hit_sym;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_CFG: if (start) state <= S_RUN;
        S_RUN: begin
          if (!hit && (32'(bit_count) >= 32'(MAX_CODE))) begin
            state <= S_ERR;
            err   <= 1'b1;
          end
        end
        S_ERR: state <= S_ERR;
        default: state <= S_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_stream_decoder.sv
// Directed bench for huffman_stream_decoder: decode, backpressure, error,
// table-write gating, input clipping and asynchronous reset.
module tb_huffman_stream_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, stop, cfg_we;
  logic [3:0] cfg_idx;
  logic [8:0] cfg_code;
  logic [3:0] cfg_len;
  logic [3:0] cfg_sym;
  logic       in_valid, in_ready;
  logic [3:0] in_data;
  logic [2:0] in_len;
  logic       out_valid, out_ready;
  logic [3:0] out_data;
  logic       err;
  logic [4:0] bit_count;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  huffman_stream_decoder #(
    .MAX_CODE(9), .SYM_W(4), .NUM_CODES(16), .IN_W(4), .BUF_W(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code),
    .cfg_len(cfg_len), .cfg_sym(cfg_sym),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [8:0] code,
                    input logic [3:0] len, input logic [3:0] sym);
    cfg_we = 1'b1; cfg_idx = idx; cfg_code = code; cfg_len = len; cfg_sym = sym;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_code = '0; cfg_len = '0; cfg_sym = '0;
    in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_err", err, 0);
    chk("rst_bit_count", bit_count, 0);
    reset = 1'b0;
    tick();

    wr(4'd0, 9'b0,   4'd1, 4'd0);
    wr(4'd1, 9'b001, 4'd3, 4'd1);
    wr(4'd2, 9'b0101, 4'd4, 4'hD);
    chk("cfg_in_ready", in_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("run_in_ready", in_ready, 1);

    // stream 0,1,0,0 -> symbols 0 then 1
    in_valid = 1'b1; in_data = 4'b0010; in_len = 3'd4;
    tick();
    in_valid = 1'b0;
    chk("t1_count_fill", bit_count, 4);
    chk("t1_no_out_yet", out_valid, 0);
    tick();
    chk("t1_sym0_valid", out_valid, 1);
    chk("t1_sym0_data", out_data, 0);
    chk("t1_count3", bit_count, 3);
    tick();
    chk("t1_sym1_valid", out_valid, 1);
    chk("t1_sym1_data", out_data, 1);
    chk("t1_count0", bit_count, 0);
    tick();
    chk("t1_idle", out_valid, 0);

    // -3 followed by four zeros, with accept and fire in the same cycle
    in_valid = 1'b1; in_data = 4'b0101; in_len = 3'd4;
    tick();
    chk("t2_count4", bit_count, 4);
    in_data = 4'b0000;
    tick();
    in_valid = 1'b0;
    chk("t2_neg3", out_data, 4'hD);
    chk("t2_count_simul", bit_count, 4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_zero_valid", out_valid, 1);
      chk("t2_zero_data", out_data, 0);
      chk("t2_zero_count", bit_count, 32'(3 - i));
    end
    tick();
    chk("t2_idle", out_valid, 0);
    chk("t2_no_err", err, 0);

    // undecodable ones -> error once 9+ bits are buffered
    in_valid = 1'b1; in_data = 4'b1111; in_len = 3'd4;
    tick(); chk("t3_count4", bit_count, 4);
    tick(); chk("t3_count8", bit_count, 8);
    tick(); chk("t3_count12", bit_count, 12);
    in_valid = 1'b0;
    chk("t3_err_not_yet", err, 0);
    chk("t3_ready_at_12", in_ready, 1);
    tick();
    chk("t3_err", err, 1);
    chk("t3_ready_err", in_ready, 0);
    tick();
    chk("t3_err_sticky", err, 1);
    stop = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; start = 1'b0;
    chk("t3_stop_err", err, 0);
    chk("t3_stop_count", bit_count, 0);
    chk("t3_stop_ready", in_ready, 0);
    tick();
    chk("t3_stop_wins", in_ready, 0);

    // backpressure
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0000; in_len = 3'd4;
    tick(); chk("t4_count4", bit_count, 4); chk("t4_ov0", out_valid, 0);
    tick(); chk("t4_ov1", out_valid, 1); chk("t4_count7", bit_count, 7);
    tick(); chk("t4_count11", bit_count, 11); chk("t4_hold_valid", out_valid, 1);
    tick(); chk("t4_count15", bit_count, 15); chk("t4_full_ready", in_ready, 0);
    tick(); chk("t4_count_hold", bit_count, 15);
    chk("t4_hold_data", out_data, 0); chk("t4_hold_valid2", out_valid, 1);
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); chk("t4_drain_first", bit_count, 14);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("t4_drain_count", bit_count, 32'(13 - i));
      chk("t4_drain_valid", out_valid, 1);
    end
    tick();
    chk("t4_drained", out_valid, 0);

    // table write ignored while running; in_len clipped to 4
    wr(4'd0, 9'b0, 4'd1, 4'd5);
    in_valid = 1'b1; in_data = 4'b0000; in_len = 3'd7;
    tick();
    in_valid = 1'b0;
    chk("t5_clip", bit_count, 4);
    tick();
    chk("t5_run_write_ignored", out_data, 0);
    repeat (4) tick();
    chk("t5_drain1", out_valid, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    wr(4'd0, 9'b0, 4'd1, 4'd5);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'b0000; in_len = 3'd4;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t5_cfg_write_taken", out_data, 5);
    repeat (4) tick();
    chk("t5_drain2", out_valid, 0);
    chk("t5_drain2_count", bit_count, 0);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'b0000; in_len = 3'd4;
    tick();
    in_len = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("t6_pre_count", bit_count, 6);
    chk("t6_pre_valid", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", out_valid, 0);
    chk("t6_async_data", out_data, 0);
    chk("t6_async_count", bit_count, 0);
    chk("t6_async_ready", in_ready, 0);
    chk("t6_async_err", err, 0);
    #2 reset = 1'b0;
    out_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 4'b0000; in_len = 3'd4;
    tick();
    tick();
    in_len = 3'd1;
    tick();
    in_valid = 1'b0;
    chk("t6_count9", bit_count, 9);
    chk("t6_no_decode", out_valid, 0);
    chk("t6_err_not_yet", err, 0);
    tick();
    chk("t6_err", err, 1);
    chk("t6_no_decode2", out_valid, 0);
    chk("t6_ready_err", in_ready, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
